legv8_fetch_sequencer: RTL and testbench

//  Instruction fetch/issue sequencer for the LEGv8 datapath. Owns the program counter.

---
 rtl/legv8_fetch_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_legv8_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// legv8_fetch_sequencer
//   Instruction fetch/issue sequencer for the LEGv8 datapath. Owns the program
//   counter. It fetches 32-bit words from instruction memory over a req/ack
//   handshake and presents each word to the controller over valid/ready. It
//   applies branch redirects at issue time and stops on a HALT opcode.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     Defined   : a REQ-state watchdog halts the sequencer with fault_o=1 when
//                 no ack arrives within TIMEOUT_CYC cycles.
//     Undefined : REQ waits indefinitely and fault_o is tied to 0.
//
// Ports
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   start_i          begin execution at pc=0 (honoured in IDLE or HALT only)
//   imem_req_o       fetch request
//   imem_addr_o      fetch address (direct copy of pc)
//   imem_ack_i       fetch complete, imem_rdata_i valid this cycle
//   imem_rdata_i     fetched word
//   instr_o          instruction register to the controller
//   instr_valid_o    instr_o holds an unissued instruction
//   instr_ready_i    controller accepts instr_o
//   branch_taken_i   redirect, looked at only in the issue-handshake cycle
//   branch_target_i  redirect address
//   pc_o             current program counter
//   icount_o         issued-instruction count (saturating)
//   halted_o         sequencer is in HALT
//   fault_o          fetch timeout occurred
// -----------------------------------------------------------------------------
module legv8_fetch_sequencer #(
  parameter int          PC_W        = 8,
  parameter logic [9:0]  HALT_OPCODE = 10'b1111111111,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [PC_W-1:0] pc_o,
  output logic [15:0]     icount_o,
  output logic            halted_o,
  output logic            fault_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [15:0]     icount_q, icount_d;
  logic            imem_req_q, instr_valid_q, halted_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  // Next-state, datapath and watchdog updates.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    icount_d = icount_q;
`ifdef FETCH_TIMEOUT_EN
    fault_d  = fault_q;
    // Counter restarts whenever REQ is (re)entered; it counts ack-less cycles.
    if ((state_q != S_REQ) || imem_ack_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // An ack in the limit cycle still wins over the watchdog.
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          if (imem_rdata_i[31:22] == HALT_OPCODE) begin
            state_d = S_HALT;
          end else begin
            state_d = S_ISSUE;
          end
`ifdef FETCH_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
`endif
        end else begin
          state_d = S_REQ;
        end
      end
      S_ISSUE: begin
        if (instr_ready_i) begin
          state_d = S_REQ;
          if (icount_q != 16'hFFFF) begin
            icount_d = icount_q + 16'd1;
          end else begin
            icount_d = icount_q;
          end
          // pc+1 wraps naturally at PC_W bits.
          if (branch_taken_i) begin
            pc_d = branch_target_i;
          end else begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_HALT: begin
        if (start_i) begin
          state_d  = S_REQ;
          pc_d     = '0;
          icount_d = 16'd0;
`ifdef FETCH_TIMEOUT_EN
          fault_d  = 1'b0;
`endif
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags (flags decoded from state_d).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= 32'd0;
      icount_q      <= 16'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      icount_q      <= icount_d;
      imem_req_q    <= (state_d == S_REQ);
      instr_valid_q <= (state_d == S_ISSUE);
      halted_q      <= (state_d == S_HALT);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Watchdog counter and sticky fault flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  assign imem_req_o    = imem_req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;
  assign icount_o      = icount_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_legv8_fetch_sequencer.sv
module tb_legv8_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [7:0]  branch_target_i = 8'd0;
  logic [7:0]  pc_o;
  logic [15:0] icount_o;
  logic        halted_o;
  logic        fault_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADD_W  = 32'h8A02_0001;  // instr[31:22] = 10'b1000101000
  localparam logic [31:0] HALT_W = 32'hFFC0_0000;  // instr[31:22] = all ones

  legv8_fetch_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .pc_o(pc_o), .icount_o(icount_o), .halted_o(halted_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One clock: inputs set after this return are sampled at the next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reset then start: on return the sequencer is in its first REQ cycle.
  task automatic reset_start();
    rst_ni = 1'b0; start_i = 1'b0; imem_ack_i = 1'b0; instr_ready_i = 1'b0; branch_taken_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
    checks++; if (halted_o !== 1'b0 || fault_o !== 1'b0) begin errors++; $display("FAIL rst_halt_fault: got %b%b want 00", halted_o, fault_o); end
    checks++; if (pc_o !== 8'd0 || icount_o !== 16'd0 || instr_o !== 32'd0) begin errors++; $display("FAIL rst_regs: pc %h icount %h instr %h want 0", pc_o, icount_o, instr_o); end
    rst_ni = 1'b1;
    tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b want 0", imem_req_o); end
  endtask

  task automatic test_single();
    int vcyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 8'h00) begin errors++; $display("FAIL start_latency: req %b addr %h want 1 00", imem_req_o, imem_addr_o); end
    tick();  // one req cycle without ack
    imem_ack_i = 1'b1; imem_rdata_i = ADD_W;
    tick();
    imem_ack_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b1 || instr_o !== ADD_W) begin errors++; $display("FAIL ack_latency: valid %b instr %h want 1 %h", instr_valid_o, instr_o, ADD_W); end
    vcyc = 0;
    if (instr_valid_o) vcyc++;
    tick();
    if (instr_valid_o) vcyc++;
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    if (instr_valid_o) vcyc++;
    checks++; if (vcyc !== 2) begin errors++; $display("FAIL valid_hold: got %0d cycles want 2", vcyc); end
    checks++; if (pc_o !== 8'h01 || icount_o !== 16'd1) begin errors++; $display("FAIL single_pc_icount: pc %h icount %0d want 01 1", pc_o, icount_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 8'h01) begin errors++; $display("FAIL issue_latency: req %b addr %h want 1 01", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_sequential();
    int dly [3] = '{0, 3, 1};
    reset_start();
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 8'(i)) begin errors++; $display("FAIL seq_addr%0d: req %b addr %h want 1 %h", i, imem_req_o, imem_addr_o, 8'(i)); end
      for (int d = 0; d < dly[i]; d++) begin
        tick();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 8'(i)) begin errors++; $display("FAIL seq_stable%0d: req %b addr %h want 1 %h", i, imem_req_o, imem_addr_o, 8'(i)); end
      end
      imem_ack_i = 1'b1; imem_rdata_i = ADD_W + 32'(i);
      tick();
      imem_ack_i = 1'b0;
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== ADD_W + 32'(i)) begin errors++; $display("FAIL seq_instr%0d: valid %b instr %h", i, instr_valid_o, instr_o); end
      instr_ready_i = 1'b1;
      tick();
      instr_ready_i = 1'b0;
    end
    checks++; if (icount_o !== 16'd3 || imem_addr_o !== 8'h03) begin errors++; $display("FAIL seq_end: icount %0d addr %h want 3 03", icount_o, imem_addr_o); end
  endtask

  task automatic test_branch();
    reset_start();
    imem_ack_i = 1'b1; imem_rdata_i = ADD_W;
    tick();
    imem_ack_i = 1'b0;
    instr_ready_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 8'h40;
    tick();
    instr_ready_i = 1'b0; branch_taken_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 8'h40) begin errors++; $display("FAIL branch_taken: req %b addr %h want 1 40", imem_req_o, imem_addr_o); end
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    branch_taken_i = 1'b1; branch_target_i = 8'h40;  // one cycle before the handshake
    tick();
    branch_taken_i = 1'b0; instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    checks++; if (imem_addr_o !== 8'h41) begin errors++; $display("FAIL branch_early_ignored: addr %h want 41", imem_addr_o); end
  endtask

  task automatic test_wrap_halt();
    reset_start();
    imem_ack_i = 1'b1; imem_rdata_i = ADD_W;
    tick();
    imem_ack_i = 1'b0;
    instr_ready_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 8'hFF;
    tick();
    instr_ready_i = 1'b0; branch_taken_i = 1'b0;
    checks++; if (imem_addr_o !== 8'hFF) begin errors++; $display("FAIL goto_ff: addr %h want ff", imem_addr_o); end
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0; instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    checks++; if (imem_addr_o !== 8'h00 || icount_o !== 16'd2) begin errors++; $display("FAIL pc_wrap: addr %h icount %0d want 00 2", imem_addr_o, icount_o); end
    imem_ack_i = 1'b1; imem_rdata_i = HALT_W;
    tick();
    imem_ack_i = 1'b0;
    checks++; if (halted_o !== 1'b1 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL halt: halted %b req %b valid %b want 1 0 0", halted_o, imem_req_o, instr_valid_o); end
    instr_ready_i = 1'b1;
    tick(); tick();
    instr_ready_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || icount_o !== 16'd2 || halted_o !== 1'b1) begin errors++; $display("FAIL halt_hold: valid %b icount %0d halted %b want 0 2 1", instr_valid_o, icount_o, halted_o); end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 8'h00 || icount_o !== 16'd0 || halted_o !== 1'b0) begin errors++; $display("FAIL restart: req %b addr %h icount %0d halted %b want 1 00 0 0", imem_req_o, imem_addr_o, icount_o, halted_o); end
  endtask

  task automatic test_reset_mid_fetch();
    reset_start();
    tick();
    rst_ni = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL async_reset: req %b want 0", imem_req_o); end
    tick();
    rst_ni = 1'b1; imem_ack_i = 1'b1; imem_rdata_i = ADD_W;
    tick();
    imem_ack_i = 1'b0;
    tick();
    checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0 || pc_o !== 8'h00 || instr_o !== 32'd0) begin errors++; $display("FAIL late_ack: valid %b req %b pc %h instr %h want 0 0 00 0", instr_valid_o, imem_req_o, pc_o, instr_o); end
  endtask

  task automatic test_back_to_back();
    // start in ISSUE is ignored; ready outside ISSUE is ignored.
    reset_start();
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || icount_o !== 16'd0) begin errors++; $display("FAIL ready_in_req: req %b icount %0d want 1 0", imem_req_o, icount_o); end
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL start_in_issue: valid %b req %b want 1 0", instr_valid_o, imem_req_o); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    reset_start();
    for (int i = 1; i < 15; i++) tick();
    checks++; if (imem_req_o !== 1'b1 || halted_o !== 1'b0) begin errors++; $display("FAIL to_before: req %b halted %b want 1 0", imem_req_o, halted_o); end
    tick();
    checks++; if (halted_o !== 1'b1 || fault_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL to_fire: halted %b fault %b req %b want 1 1 0", halted_o, fault_o, imem_req_o); end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (fault_o !== 1'b0 || imem_req_o !== 1'b1) begin errors++; $display("FAIL to_clear: fault %b req %b want 0 1", fault_o, imem_req_o); end
    for (int i = 1; i < 15; i++) tick();
    imem_ack_i = 1'b1; imem_rdata_i = ADD_W;
    tick();
    imem_ack_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b1 || fault_o !== 1'b0 || halted_o !== 1'b0) begin errors++; $display("FAIL to_ack_wins: valid %b fault %b halted %b want 1 0 0", instr_valid_o, fault_o, halted_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_sequential();
    test_branch();
    test_wrap_halt();
    test_reset_mid_fetch();
    test_back_to_back();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
